// File: rtl/serial_nibble_deser.sv
// Serial-to-parallel deserializer: assembles a handshaked bit stream into WIDTH-bit words,
// either as non-overlapping frames or as a sliding window, with a registered word output.
module serial_nibble_deser #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit SLIDING   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CW-1:0]    cnt;
    logic             next_completes;
    logic             accept;

    generate
        if (MSB_FIRST) begin : g_msb
            assign shreg_nxt = {shreg[WIDTH-2:0], bit_in};
        end else begin : g_lsb
            assign shreg_nxt = {bit_in, shreg[WIDTH-1:1]};
        end
    endgenerate

    // In sliding mode every bit after the window fills yields a word.
    assign next_completes = SLIDING ? (cnt >= CNT_LAST) : (cnt == CNT_LAST);

    // Only a completing bit can stall, and only against an unconsumed held word.
    assign bit_ready = flush | ~(word_valid & ~word_ready & next_completes);
    assign accept    = bit_valid & bit_ready & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg      <= '0;
            cnt        <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
        end else begin
            if (flush) begin
                shreg <= '0;
                cnt   <= '0;
            end else if (accept) begin
                shreg <= shreg_nxt;
                if (next_completes)
                    cnt <= SLIDING ? CNT_FULL : CW'(0);
                else
                    cnt <= cnt + 1'b1;
            end

            // A completion while full replaces the word in the same cycle it is consumed.
            if (accept && next_completes) begin
                word_out   <= shreg_nxt;
                word_valid <= 1'b1;
            end else if (word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_nibble_deser.sv
// Bench for serial_nibble_deser: three configurations driven in lockstep and checked
// each cycle against a bit-history reference model, plus directed spot checks.
module tb_serial_nibble_deser;
    logic clk = 1'b0;
    logic rst_n, flush, bit_in, bit_valid, word_ready;
    logic [2:0]      rdy_o, vld_o;
    logic [2:0][3:0] wo;

    int total = 0;
    int bad   = 0;

    // config 0: MSB-first framed, 1: LSB-first framed, 2: MSB-first sliding
    int         m_cnt  [3];
    logic [15:0] m_hist[3];
    logic        m_held[3];
    logic [3:0]  m_word[3];
    bit          m_sld [3] = '{1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    serial_nibble_deser #(.WIDTH(4), .MSB_FIRST(1'b1), .SLIDING(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(rdy_o[0]), .word_out(wo[0]), .word_valid(vld_o[0]), .word_ready(word_ready));
    serial_nibble_deser #(.WIDTH(4), .MSB_FIRST(1'b0), .SLIDING(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(rdy_o[1]), .word_out(wo[1]), .word_valid(vld_o[1]), .word_ready(word_ready));
    serial_nibble_deser #(.WIDTH(4), .MSB_FIRST(1'b1), .SLIDING(1'b1)) u_sld (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(rdy_o[2]), .word_out(wo[2]), .word_valid(vld_o[2]), .word_ready(word_ready));

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Word from the last 4 received bits (hist[0] is the newest bit).
    function automatic logic [3:0] form(input int c, input logic [15:0] h);
        logic [3:0] w;
        for (int i = 0; i < 4; i++)
            w[i] = (c == 1) ? h[3-i] : h[i];
        return w;
    endfunction

    task automatic reset_model();
        for (int c = 0; c < 3; c++) begin
            m_cnt[c] = 0; m_hist[c] = '0; m_held[c] = 1'b0; m_word[c] = '0;
        end
    endtask

    // One clock: drive inputs, check all outputs before the edge, advance the model.
    task automatic step(input logic b, input logic v, input logic wr, input logic fl, input logic rn);
        bit comp, rdy, nheld;
        bit_in = b; bit_valid = v; word_ready = wr; flush = fl; rst_n = rn;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            comp = m_sld[c] ? (m_cnt[c] >= 3) : (m_cnt[c] == 3);
            rdy  = fl || !(m_held[c] && !wr && comp);
            chk($sformatf("rdy%0d", c), 16'(rdy_o[c]), 16'(rdy));
            chk($sformatf("vld%0d", c), 16'(vld_o[c]), 16'(m_held[c]));
            chk($sformatf("word%0d", c), 16'(wo[c]), 16'(m_word[c]));
            if (rn) begin
                nheld = m_held[c] && !wr;
                if (fl) begin
                    m_cnt[c] = 0; m_hist[c] = '0;
                end else if (v && rdy) begin
                    m_hist[c] = {m_hist[c][14:0], b};
                    m_cnt[c]++;
                    if (comp) begin
                        m_word[c] = form(c, m_hist[c]);
                        nheld = 1'b1;
                        m_cnt[c] = m_sld[c] ? 4 : 0;
                    end
                end
                m_held[c] = nheld;
            end
        end
        if (!rn) reset_model();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] seq;
        flush = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b1; rst_n = 1'b0;
        reset_model();
        @(posedge clk); #1;
        step(0, 0, 1, 0, 0);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rst_vld%0d", c), 16'(vld_o[c]), 16'h0);
            chk($sformatf("rst_word%0d", c), 16'(wo[c]), 16'h0);
            chk($sformatf("rst_rdy%0d", c), 16'(rdy_o[c]), 16'h1);
        end

        // basic MSB-first
        seq = 4'b1010;
        for (int i = 3; i >= 0; i--) begin
            step(seq[i], 1, 1, 0, 1);
            if (i == 1) chk("msb_early_vld", 16'(vld_o[0]), 16'h0);
        end
        chk("msb_word", 16'(wo[0]), 16'hA);
        chk("msb_vld", 16'(vld_o[0]), 16'h1);
        step(0, 0, 1, 0, 1);
        chk("msb_single_vld", 16'(vld_o[0]), 16'h0);

        // LSB-first
        step(0, 0, 1, 0, 0);
        seq = 4'b0101;
        for (int i = 3; i >= 0; i--) step(seq[i], 1, 1, 0, 1);
        chk("lsb_word_a", 16'(wo[1]), 16'hA);
        seq = 4'b1100;
        for (int i = 3; i >= 0; i--) step(seq[i], 1, 1, 0, 1);
        chk("lsb_word_b", 16'(wo[1]), 16'h3);

        // sliding window
        step(0, 0, 1, 0, 0);
        step(1, 1, 1, 0, 1); step(0, 1, 1, 0, 1); step(1, 1, 1, 0, 1);
        chk("sld_early_vld", 16'(vld_o[2]), 16'h0);
        step(0, 1, 1, 0, 1);
        chk("sld_w0", 16'(wo[2]), 16'hA);
        step(1, 1, 1, 0, 1);
        chk("sld_w1", 16'(wo[2]), 16'h5);
        chk("sld_w1_vld", 16'(vld_o[2]), 16'h1);
        step(0, 1, 1, 0, 1);
        chk("sld_w2", 16'(wo[2]), 16'hA);

        // backpressure
        step(0, 0, 1, 0, 0);
        step(1, 1, 1, 0, 1); step(0, 1, 1, 0, 1); step(1, 1, 1, 0, 1); step(0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1);
        chk("bp_held_word", 16'(wo[0]), 16'hA);
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 0, 0, 1);
            chk("bp_stall_rdy", 16'(rdy_o[0]), 16'h0);
            chk("bp_stall_word", 16'(wo[0]), 16'hA);
        end
        step(1, 1, 1, 0, 1);
        chk("bp_next_word", 16'(wo[0]), 16'hF);
        chk("bp_next_vld", 16'(vld_o[0]), 16'h1);

        // flush
        step(0, 0, 1, 0, 0);
        step(1, 1, 1, 0, 1); step(1, 1, 1, 0, 1); step(1, 1, 1, 1, 1);
        chk("fl_no_word", 16'(vld_o[0]), 16'h0);
        step(1, 1, 1, 0, 1); step(0, 1, 1, 0, 1); step(1, 1, 1, 0, 1);
        chk("fl_partial_vld", 16'(vld_o[0]), 16'h0);
        step(0, 1, 0, 0, 1);
        chk("fl_word", 16'(wo[0]), 16'hA);
        step(0, 0, 0, 1, 1);
        chk("fl_held_vld", 16'(vld_o[0]), 16'h1);
        chk("fl_held_word", 16'(wo[0]), 16'hA);

        // reset mid-word with a held word
        step(1, 1, 0, 0, 1); step(1, 1, 0, 0, 1); step(1, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("mid_rst_vld", 16'(vld_o[0]), 16'h0);
        chk("mid_rst_word", 16'(wo[0]), 16'h0);
        seq = 4'b0110;
        for (int i = 3; i >= 0; i--) step(seq[i], 1, 1, 0, 1);
        chk("mid_rst_after", 16'(wo[0]), 16'h6);

        // randomized traffic
        for (int n = 0; n < 3000; n++)
            step(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 99) < 5, !($urandom_range(0, 99) < 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
